// File: rtl/pll_phase_ctrl_pkg.sv
// Shared types and constants for the EHXPLLL dynamic phase-adjust controller.
package pll_phase_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_PULSE,
    ST_HOLD,
    ST_LOAD,
    ST_DONE
  } state_e;

  // PHASESEL encodings for the four PLL outputs.
  localparam logic [1:0] SEL_CLKOP  = 2'd0;
  localparam logic [1:0] SEL_CLKOS  = 2'd1;
  localparam logic [1:0] SEL_CLKOS2 = 2'd2;
  localparam logic [1:0] SEL_CLKOS3 = 2'd3;

  // PHASESTEP and PHASELOADREG are active-low strobes that rest high.
  localparam logic PHASESTEP_IDLE    = 1'b1;
  localparam logic PHASELOADREG_IDLE = 1'b1;

  // Bits needed for a down-counter loaded with (cycles-1) for the longest phase.
  function automatic int timer_width(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    m = (m > c) ? m : c;
    return (m <= 1) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser for bringing asynchronous levels into clk.
module sync_2ff #(
  parameter int           W         = 1,
  parameter logic [W-1:0] RESET_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;

  // Two-stage register chain; the first stage may go metastable.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments make both stages sample the old values, forming a real two-flop chain.
    if (rst) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/pll_phase_ctrl.sv
// Sequences PHASESEL/PHASEDIR/PHASESTEP/PHASELOADREG of an ECP5 EHXPLLL and
// tracks the accumulated phase position of each of its four outputs.
module pll_phase_ctrl
  import pll_phase_ctrl_pkg::*;
#(
  parameter int SETUP_CYCLES = 2,
  parameter int PULSE_CYCLES = 4,
  parameter int HOLD_CYCLES  = 2,
  parameter int COUNT_W      = 4,
  parameter int POS_W        = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [1:0]         req_sel,
  input  logic               req_dir,
  input  logic [COUNT_W-1:0] req_count,
  input  logic               req_load,
  input  logic               pll_locked,
  output logic [1:0]         phasesel,
  output logic               phasedir,
  output logic               phasestep,
  output logic               phaseloadreg,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [4*POS_W-1:0] phase_pos
);

  localparam int TIMER_W = timer_width(SETUP_CYCLES, PULSE_CYCLES, HOLD_CYCLES);

  state_e             state_q, state_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [COUNT_W:0]   rem_q, rem_d;       // one extra bit so count 0 can mean 2^COUNT_W
  logic               load_q, load_d;
  logic               lost_q, lost_d;     // sticky: lock dropped during this request
  logic [1:0]         phasesel_q, phasesel_d;
  logic               phasedir_q, phasedir_d;
  logic               phasestep_q, phasestep_d;
  logic               phaseloadreg_q, phaseloadreg_d;
  logic [POS_W-1:0]   pos_q [4];
  logic [POS_W-1:0]   pos_d [4];
  logic               lock_ok;
  logic               lost_now;
  logic               accept;

  sync_2ff #(.W(1), .RESET_VAL(1'b0)) u_lock_sync (
    .clk (clk),
    .rst (rst),
    .d_i (pll_locked),
    .q_o (lock_ok)
  );

  assign accept   = req_valid && req_ready;
  assign lost_now = lost_q || !lock_ok;

  // Next-state and strobe sequencing for one request of one or more steps.
  always_comb begin
    // NOTE: every variable gets its hold value first, so no path through the case can infer a latch.
    state_d        = state_q;
    timer_d        = timer_q;
    rem_d          = rem_q;
    load_d         = load_q;
    lost_d         = lost_q;
    phasesel_d     = phasesel_q;
    phasedir_d     = phasedir_q;
    phasestep_d    = phasestep_q;
    phaseloadreg_d = phaseloadreg_q;
    pos_d          = pos_q;

    if (state_q != ST_IDLE && !lock_ok) lost_d = 1'b1;

    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          phasesel_d = req_sel;
          phasedir_d = req_dir;
          rem_d      = {req_count == '0, req_count};
          load_d     = req_load;
          lost_d     = 1'b0;
          timer_d    = TIMER_W'(SETUP_CYCLES - 1);
          state_d    = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (timer_q == '0) begin
          phasestep_d = ~PHASESTEP_IDLE;
          timer_d     = TIMER_W'(PULSE_CYCLES - 1);
          state_d     = ST_PULSE;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      ST_PULSE: begin
        if (timer_q == '0) begin
          phasestep_d       = PHASESTEP_IDLE;
          pos_d[phasesel_q] = phasedir_q ? pos_q[phasesel_q] - POS_W'(1)
                                         : pos_q[phasesel_q] + POS_W'(1);
          rem_d             = rem_q - 1'b1;
          timer_d           = TIMER_W'(HOLD_CYCLES - 1);
          state_d           = ST_HOLD;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      ST_HOLD: begin
        if (timer_q == '0) begin
          if (rem_q != '0 && !lost_now) begin
            timer_d = TIMER_W'(SETUP_CYCLES - 1);
            state_d = ST_SETUP;
          end else if (load_q && !lost_now) begin
            phaseloadreg_d = ~PHASELOADREG_IDLE;
            timer_d        = TIMER_W'(PULSE_CYCLES - 1);
            state_d        = ST_LOAD;
          end else begin
            state_d = ST_DONE;
          end
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      ST_LOAD: begin
        if (timer_q == '0) begin
          phaseloadreg_d = PHASELOADREG_IDLE;
          state_d        = ST_DONE;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      ST_DONE: begin
        lost_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, strobe and position registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      timer_q        <= '0;
      rem_q          <= '0;
      load_q         <= 1'b0;
      lost_q         <= 1'b0;
      phasesel_q     <= SEL_CLKOP;
      phasedir_q     <= 1'b0;
      phasestep_q    <= PHASESTEP_IDLE;
      phaseloadreg_q <= PHASELOADREG_IDLE;
      // NOTE: the position array is architecturally visible state, so unlike a data memory it is reset.
      for (int n = 0; n < 4; n++) pos_q[n] <= '0;
    end else begin
      state_q        <= state_d;
      timer_q        <= timer_d;
      rem_q          <= rem_d;
      load_q         <= load_d;
      lost_q         <= lost_d;
      phasesel_q     <= phasesel_d;
      phasedir_q     <= phasedir_d;
      phasestep_q    <= phasestep_d;
      phaseloadreg_q <= phaseloadreg_d;
      pos_q          <= pos_d;
    end
  end

  for (genvar n = 0; n < 4; n++) begin : g_pos
    assign phase_pos[n*POS_W +: POS_W] = pos_q[n];
  end

  assign req_ready    = (state_q == ST_IDLE) && lock_ok;
  assign busy         = (state_q != ST_IDLE);
  assign done         = (state_q == ST_DONE);
  assign err          = (state_q == ST_DONE) && lost_q;
  assign phasesel     = phasesel_q;
  assign phasedir     = phasedir_q;
  assign phasestep    = phasestep_q;
  assign phaseloadreg = phaseloadreg_q;

endmodule

// File: tb/tb_pll_phase_ctrl.sv
// Directed and randomized bench for pll_phase_ctrl with a cycle-level model
// of pulse timing and a modular-arithmetic model of the phase positions.
module tb_pll_phase_ctrl;

  localparam int SETUP = 2;
  localparam int PULSE = 4;
  localparam int HOLD  = 2;
  localparam int POS_W = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_sel = '0;
  logic        req_dir = 1'b0;
  logic [3:0]  req_count = '0;
  logic        req_load = 1'b0;
  logic        pll_locked = 1'b1;
  logic [1:0]  phasesel;
  logic        phasedir;
  logic        phasestep;
  logic        phaseloadreg;
  logic        busy;
  logic        done;
  logic        err;
  logic [11:0] phase_pos;

  pll_phase_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_sel      (req_sel),
    .req_dir      (req_dir),
    .req_count    (req_count),
    .req_load     (req_load),
    .pll_locked   (pll_locked),
    .phasesel     (phasesel),
    .phasedir     (phasedir),
    .phasestep    (phasestep),
    .phaseloadreg (phaseloadreg),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .phase_pos    (phase_pos)
  );

  always #5 clk = ~clk;

  // ---------------- event recorder (mid-cycle sampling) ----------------
  int   cyc = 0;
  bit   prev_step = 1'b1;
  bit   prev_lreg = 1'b1;
  logic [1:0] prev_sel = '0;
  logic prev_dir = 1'b0;
  int   low_len = 0;
  int   llow_len = 0;
  int   viol = 0;
  int   stray_err = 0;
  int   fall_q[$];
  int   width_q[$];
  int   lfall_q[$];
  int   lwidth_q[$];
  int   done_q[$];
  bit   errd_q[$];

  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      if (phasestep === 1'b0 && (phasesel !== prev_sel || phasedir !== prev_dir)) viol++;
      if (prev_step && phasestep === 1'b0) begin fall_q.push_back(cyc); low_len = 0; end
      if (phasestep === 1'b0) low_len++;
      if (!prev_step && phasestep === 1'b1) width_q.push_back(low_len);
      if (prev_lreg && phaseloadreg === 1'b0) begin lfall_q.push_back(cyc); llow_len = 0; end
      if (phaseloadreg === 1'b0) llow_len++;
      if (!prev_lreg && phaseloadreg === 1'b1) lwidth_q.push_back(llow_len);
      if (done === 1'b1) begin done_q.push_back(cyc); errd_q.push_back(err === 1'b1); end
      if (err === 1'b1 && done !== 1'b1) stray_err++;
    end
    prev_step = (phasestep === 1'b1);
    prev_lreg = (phaseloadreg === 1'b1);
    prev_sel  = phasesel;
    prev_dir  = phasedir;
  end

  // ---------------- checking and model ----------------
  int checks = 0;
  int errors = 0;
  int exp_pos [4] = '{0, 0, 0, 0};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] model_vec();
    logic [11:0] v;
    for (int n = 0; n < 4; n++) v[n*POS_W +: POS_W] = POS_W'(exp_pos[n]);
    return v;
  endfunction

  function automatic void model_step(input int s, input bit d, input int n);
    exp_pos[s] = (((exp_pos[s] + (d ? -n : n)) % 8) + 8) % 8;
  endfunction

  // Waits for req_ready (checking the current cycle first), accepts, leaves valid
  // high when keep is set, and returns the accept cycle index.
  task automatic send_req(input logic [1:0] s, input logic d, input logic [3:0] c,
                          input logic l, input bit keep, output int acc);
    bit ok = 1'b0;
    acc = -1;
    req_sel = s; req_dir = d; req_count = c; req_load = l; req_valid = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if (req_ready === 1'b1) begin ok = 1'b1; acc = cyc; break; end
      @(negedge clk); #1;
    end
    chk("accept", {63'd0, ok}, 64'd1);
    @(posedge clk); #1;
    if (!keep) begin
      req_valid = 1'b0;
      req_sel = 2'($urandom); req_dir = 1'($urandom);
      req_count = 4'($urandom); req_load = 1'($urandom);
    end
    @(negedge clk); #1;
    chk("busy_after_accept", {63'd0, busy}, 64'd1);
    chk("ready_while_busy", {63'd0, req_ready}, 64'd0);
  endtask

  task automatic wait_done(input int bd);
    bit got = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if (done_q.size() > bd) begin got = 1'b1; break; end
      @(negedge clk); #1;
    end
    chk("done_seen", {63'd0, got}, 64'd1);
  endtask

  task automatic check_req(input string tag, input int acc, input int bf, input int bw,
                           input int blf, input int blw, input int bd, input int v0,
                           input int n, input bit load_exp, input bit err_exp);
    int bad_w = 0;
    int bad_p = 0;
    int last_f;
    chk({tag, "_npulse"}, 64'(fall_q.size() - bf), 64'(n));
    chk({tag, "_nwidth"}, 64'(width_q.size() - bw), 64'(n));
    for (int i = bw; i < width_q.size(); i++) if (width_q[i] != PULSE) bad_w++;
    chk({tag, "_widths"}, 64'(bad_w), 64'd0);
    if (fall_q.size() - bf == n && n > 0 && done_q.size() > bd) begin
      chk({tag, "_latency"}, 64'(fall_q[bf] - acc), 64'(1 + SETUP));
      for (int i = bf + 1; i < bf + n; i++)
        if (fall_q[i] - fall_q[i-1] != SETUP + PULSE + HOLD) bad_p++;
      chk({tag, "_period"}, 64'(bad_p), 64'd0);
      last_f = fall_q[bf + n - 1];
      chk({tag, "_done_time"}, 64'(done_q[bd] - last_f),
          64'(PULSE + HOLD + (load_exp ? PULSE : 0)));
      if (load_exp && lfall_q.size() > blf)
        chk({tag, "_load_time"}, 64'(lfall_q[blf] - last_f), 64'(PULSE + HOLD));
    end
    chk({tag, "_nload"}, 64'(lfall_q.size() - blf), 64'(load_exp));
    if (load_exp && lwidth_q.size() > blw)
      chk({tag, "_load_width"}, 64'(lwidth_q[blw]), 64'(PULSE));
    if (done_q.size() > bd) chk({tag, "_err"}, {63'd0, errd_q[bd]}, {63'd0, err_exp});
    chk({tag, "_sel_stable"}, 64'(viol - v0), 64'd0);
    chk({tag, "_busy_in_done"}, {63'd0, busy}, 64'd1);
    chk({tag, "_phase_pos"}, {52'd0, phase_pos}, {52'd0, model_vec()});
    @(negedge clk); #1;
    chk({tag, "_busy_idle"}, {63'd0, busy}, 64'd0);
    chk({tag, "_done_1cyc"}, {63'd0, done}, 64'd0);
  endtask

  // One complete request: issue, wait for completion, compare against the model.
  task automatic full_req(input string tag, input logic [1:0] s, input logic d,
                          input logic [3:0] c, input logic l);
    int bf, bw, blf, blw, bd, v0, acc, n;
    bf = fall_q.size(); bw = width_q.size(); blf = lfall_q.size();
    blw = lwidth_q.size(); bd = done_q.size(); v0 = viol;
    n = (c == 0) ? 16 : int'(c);
    send_req(s, d, c, l, 1'b0, acc);
    wait_done(bd);
    model_step(s, d, n);
    check_req(tag, acc, bf, bw, blf, blw, bd, v0, n, l, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int bf, bw, blf, blw, bd, v0, acc, acc_b, bd_a, got;
    logic [1:0] rs;
    logic       rd;
    logic [3:0] rc;
    logic       rl;

    // Reset values
    repeat (3) @(negedge clk);
    #1;
    chk("rst_phasesel", {62'd0, phasesel}, 64'd0);
    chk("rst_phasedir", {63'd0, phasedir}, 64'd0);
    chk("rst_phasestep", {63'd0, phasestep}, 64'd1);
    chk("rst_phaseloadreg", {63'd0, phaseloadreg}, 64'd1);
    chk("rst_flags", {61'd0, busy, done, err}, 64'd0);
    chk("rst_ready", {63'd0, req_ready}, 64'd0);
    chk("rst_phase_pos", {52'd0, phase_pos}, 64'd0);
    rst = 1'b0;
    @(negedge clk); #1;

    // Directed scenarios
    full_req("single_adv", 2'd1, 1'b0, 4'd1, 1'b0);
    full_req("burst_wrap", 2'd0, 1'b1, 4'd3, 1'b0);
    chk("burst_wrap_pos0", {61'd0, phase_pos[2:0]}, 64'd5);
    full_req("count0_load", 2'd3, 1'b0, 4'd0, 1'b1);

    // Lock loss during the second of five steps
    bf = fall_q.size(); bw = width_q.size(); blf = lfall_q.size();
    blw = lwidth_q.size(); bd = done_q.size(); v0 = viol;
    send_req(2'd2, 1'b0, 4'd5, 1'b1, 1'b0, acc);
    got = 0;
    for (int i = 0; i < 100; i++) begin
      if (fall_q.size() >= bf + 2) begin got = 1; break; end
      @(negedge clk); #1;
    end
    chk("lock_second_pulse", 64'(got), 64'd1);
    pll_locked = 1'b0;
    wait_done(bd);
    model_step(2, 1'b0, 2);
    check_req("lock_loss", acc, bf, bw, blf, blw, bd, v0, 2, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      chk("lock_ready_low", {63'd0, req_ready}, 64'd0);
      @(negedge clk); #1;
    end
    pll_locked = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("lock_ready_back", {63'd0, req_ready}, 64'd1);

    // Back-to-back with req_valid held high
    bf = fall_q.size(); bw = width_q.size(); blf = lfall_q.size();
    blw = lwidth_q.size(); bd = done_q.size(); v0 = viol;
    send_req(2'd1, 1'b1, 4'd2, 1'b0, 1'b1, acc);
    req_sel = 2'd0; req_dir = 1'b0; req_count = 4'd2; req_load = 1'b1;
    wait_done(bd);
    bd_a = bd;
    model_step(1, 1'b1, 2);
    check_req("b2b_first", acc, bf, bw, blf, blw, bd, v0, 2, 1'b0, 1'b0);
    bf = fall_q.size(); bw = width_q.size(); blf = lfall_q.size();
    blw = lwidth_q.size(); bd = done_q.size(); v0 = viol;
    send_req(2'd0, 1'b0, 4'd2, 1'b1, 1'b0, acc_b);
    if (done_q.size() > bd_a)
      chk("b2b_accept_after_done", 64'(acc_b - done_q[bd_a]), 64'd1);
    wait_done(bd);
    model_step(0, 1'b0, 2);
    check_req("b2b_second", acc_b, bf, bw, blf, blw, bd, v0, 2, 1'b1, 1'b0);

    // Randomized requests
    for (int k = 0; k < 6; k++) begin
      rs = 2'($urandom); rd = 1'($urandom);
      rc = 4'($urandom_range(1, 4)); rl = 1'($urandom);
      full_req($sformatf("rand%0d", k), rs, rd, rc, rl);
    end

    // Reset during PULSE
    bf = fall_q.size();
    send_req(2'd1, 1'b0, 4'd2, 1'b0, 1'b0, acc);
    got = 0;
    for (int i = 0; i < 50; i++) begin
      if (fall_q.size() > bf) begin got = 1; break; end
      @(negedge clk); #1;
    end
    chk("rstpulse_in_pulse", {63'd0, phasestep}, 64'd0);
    rst = 1'b1;
    @(negedge clk); #1;
    chk("rstpulse_phasestep", {63'd0, phasestep}, 64'd1);
    chk("rstpulse_busy", {63'd0, busy}, 64'd0);
    chk("rstpulse_phase_pos", {52'd0, phase_pos}, 64'd0);
    chk("rstpulse_loadreg_sel", {61'd0, phaseloadreg, phasesel}, 64'd4);
    rst = 1'b0;
    for (int n = 0; n < 4; n++) exp_pos[n] = 0;
    @(negedge clk); #1;
    full_req("after_rst", 2'($urandom), 1'($urandom), 4'($urandom_range(1, 3)), 1'b1);

    chk("stray_err", 64'(stray_err), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pll_phase_ctrl.md
Name: pll_phase_ctrl

Overview:
- Drives the dynamic phase-adjust port of the ECP5 EHXPLLL (PHASESEL, PHASEDIR, PHASESTEP, PHASELOADREG). Our PLL wrappers tie this port off today.
- Accepts step requests over a valid/ready handshake and emits correctly timed step pulses to the PLL.
- Tracks the accumulated phase position of each of the four PLL outputs.
- Sits in the system clock domain beside the PLL wrapper; software or a calibration FSM issues requests.

Parameters:
- SETUP_CYCLES, 2, cycles PHASESEL/PHASEDIR are held stable before the step pulse.
- PULSE_CYCLES, 4, cycles PHASESTEP is held low per step.
- HOLD_CYCLES, 2, cycles PHASESEL/PHASEDIR are held stable after the pulse before the next step or idle.
- COUNT_W, 4, width of the per-request step count.
- POS_W, 3, width of each output's phase position; wraps modulo 2^POS_W (8 steps = one VCO period).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- req_valid  in  1  step request valid
- req_ready  out  1  high only in IDLE while lock_ok
- req_sel  in  2  PLL output select: 0=CLKOP, 1=CLKOS, 2=CLKOS2, 3=CLKOS3
- req_dir  in  1  0=advance (+1 per step), 1=retard (-1 per step)
- req_count  in  COUNT_W  number of steps; 0 means 2^COUNT_W
- req_load  in  1  pulse PHASELOADREG after the final step
- pll_locked  in  1  asynchronous PLL LOCK
- phasesel  out  2  to PLL PHASESEL[1:0]
- phasedir  out  1  to PLL PHASEDIR
- phasestep  out  1  to PLL PHASESTEP, idle high
- phaseloadreg  out  1  to PLL PHASELOADREG, idle high
- busy  out  1  high whenever not in IDLE
- done  out  1  one-cycle pulse when a request completes
- err  out  1  one-cycle pulse with done if lock was lost during the request
- phase_pos  out  4*POS_W  per-output position; output n occupies bits [n*POS_W +: POS_W]

Behaviour:
- Reset values:
  - phasesel=0, phasedir=0, phasestep=1, phaseloadreg=1
  - busy=0, done=0, err=0, req_ready=0
  - phase_pos all 0, state=IDLE, lock synchroniser cleared
- pll_locked passes through a 2-FF synchroniser to give lock_ok.
- Handshake: accept on req_valid && req_ready. On accept, latch sel, dir, count and load into internal registers; the req_* inputs are ignored afterwards.
- States:
  - IDLE: on accept, drive phasesel/phasedir from the latched values and go to SETUP with timer=SETUP_CYCLES-1.
  - SETUP: count the timer down; at 0, go to PULSE with phasestep=0 and timer=PULSE_CYCLES-1.
  - PULSE: at timer 0, set phasestep=1, update phase_pos[sel] by +1 (dir=0) or -1 (dir=1) modulo 2^POS_W, decrement remaining, and go to HOLD with timer=HOLD_CYCLES-1.
  - HOLD: at timer 0:
    - if remaining!=0 and lock_ok, go to SETUP (phasesel/phasedir stay unchanged);
    - else if load, go to LOAD with phaseloadreg=0 for PULSE_CYCLES;
    - else go to DONE.
  - LOAD: at timer 0, set phaseloadreg=1 and go to DONE.
  - DONE: pulse done for one cycle (err too if the sticky lock-lost flag is set), clear the flag, go to IDLE.
- Accept-to-first-falling-edge latency on phasestep: 1+SETUP_CYCLES cycles.
- Step period: SETUP+PULSE+HOLD cycles.
- Lock loss: lock_ok low in any non-IDLE state sets the sticky flag. The current pulse always completes; no pulse is ever truncated. No further steps are issued; LOAD is skipped and the FSM goes straight to DONE.
- phasesel and phasedir change only in IDLE→SETUP, so they are never changed while phasestep=0.
- phase_pos wrap: retarding from 0 gives 2^POS_W-1; advancing from 2^POS_W-1 gives 0.
- Reset mid-operation returns everything to reset values on the next edge. phasestep may rise early; this is acceptable because the PLL steps on the falling edge.
- A request arriving while busy stalls (req_ready=0) and is never dropped.

Decomposition:
- Shared package holds the state enum, the output-select constants (CLKOP..CLKOS3), and the idle levels for PHASESTEP/PHASELOADREG.
- One sub-module: sync_2ff (a generic 2-flop synchroniser, reused for pll_locked).

Test Plan:
- Single advance: locked=1, sel=1, dir=0, count=1, load=0 → exactly one phasestep low pulse of 4 cycles, falling 3 cycles after accept; phase_pos[1]=1; done 1 cycle after HOLD ends; err=0.
- Burst with wrap: sel=0, dir=1, count=3 from pos 0 → 3 pulses with 8-cycle period, phasesel=0 throughout, phase_pos[0]=5.
- Count zero and load: count=0, load=1, sel=3 → 16 pulses, then one phaseloadreg low pulse of 4 cycles; phase_pos[3] = 16 mod 8 = 0.
- Lock loss: count=5, drop pll_locked during pulse 2 → pulse 2 completes full width, no pulse 3, phase_pos=2, done and err pulse together; req_ready stays 0 until lock_ok is back.
- Back-to-back: hold req_valid high with two requests → second accepted only in IDLE after done; phasesel/phasedir never change while phasestep=0 (assertion).
- Reset during PULSE → next cycle phasestep=1, busy=0, all phase_pos=0.
